hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//   Issue-side hazard tracker for the 5-stage core; pairs with the EX-stage bypass network.
//   Holds a shadow record of in-flight register writers (EX, MEM) plus a multi-cycle mul/div
//   unit's pending destination. Stalls ID when a source cannot be served by bypass:
//   load-use (loaded data not ready in time) or mul/div result not yet produced.
//   Sits beside the ID/EX pipeline register; drives IF/ID hold and EX bubble insertion.
// PARAMETERS
//   MD_LAT  4  cycles from mul/div issue to result valid (>=1)
//   CNT_W   3  width of mul/div countdown counter; must hold MD_LAT
// PORTS
//   clk            in   1  core clock, rising edge
//   rstn           in   1  asynchronous active-low reset
//   ID_valid       in   1  ID holds a real instruction
//   ID_rs          in   5  source register 1
//   ID_rt          in   5  source register 2
//   ID_useRs       in   1  instruction reads rs
//   ID_useRt       in   1  instruction reads rt
//   ID_RegWrite    in   1  instruction writes a register
//   ID_RegSrc      in   2  writeback source, ctrl_encode_def.v encoding (REGSRC_MEM = load)
//   ID_WriteReg    in   5  destination register
//   ID_isMD        in   1  instruction is a mul/div (result via MD unit)
//   flush          in   1  squash ID instruction and EX shadow entry (branch redirect)
//   stall          out  1  hold PC and IF/ID this cycle
//   bubble         out  1  insert NOP into ID/EX this cycle (== stall)
//   stall_cause    out  2  00 none, 01 load-use, 10 mul/div, 11 both
//   md_busy        out  1  mul/div operation in flight
//   md_dest        out  5  destination of in-flight mul/div (0 when idle)
//   md_done        out  1  one-cycle pulse: mul/div result valid this cycle
// BEHAVIOUR
//   Reset (rstn low, async): EX/MEM shadow entries invalid, md counter 0, md_busy 0,
//     md_dest 0, md_done 0. stall/bubble/stall_cause are combinational, therefore 0 while
//     ID_valid is low.
//   Shadow entry = {valid, WriteReg, isLoad}. Each posedge: MEM <= EX;
//     EX <= issued ID entry if (ID_valid & ID_RegWrite & !stall & !flush), else invalid.
//   Issue = ID_valid & !stall & !flush.
//   Register 0 never produces a hazard (source or destination).
//   Load-use hazard: EX.valid & EX.isLoad & EX.WriteReg!=0 &
//     ((ID_useRs & ID_rs==EX.WriteReg) | (ID_useRt & ID_rt==EX.WriteReg)).
//     Exactly one stall cycle; the load then moves to MEM and is forwarded.
//     A load in MEM never causes a stall.
//   Mul/div FSM: IDLE -> BUSY on issue with ID_isMD: counter <= MD_LAT, md_dest <= ID_WriteReg.
//     BUSY: counter decrements each cycle; when counter == 1, next state DONE.
//     DONE: md_done=1 for one cycle, md_busy=0, md_dest cleared -> IDLE.
//     An MD issue in the DONE cycle is legal and goes straight to BUSY.
//   Mul/div hazard (while BUSY): ID source == md_dest (nonzero), OR ID_isMD (single unit),
//     OR ID_RegWrite & ID_WriteReg == md_dest (WAW).
//   stall = ID_valid & !flush & (loaduse | mdhaz). The stall is asserted in the same cycle
//     the hazard is seen.
//   flush has priority over stall: ID is not issued; EX entry is invalidated at the next
//     edge; the MEM entry and the MD FSM are unaffected (an MD op already issued completes).
//   Reset mid-operation aborts the MD op; no md_done pulse follows.
// TESTING
//   lw $8; next add $9,$8,$10 -> stall=1, cause=01 for exactly 1 cycle; then issues.
//   lw $8; nop; add $9,$8,$8 -> stall never asserted.
//   lw $0; add $9,$0,$0 -> no stall.
//   mul $5 (MD_LAT=4); then add $6,$5,$1 -> md_busy 4 cycles, stall until the md_done cycle,
//     add issues on md_done.
//   mul $5; then div $7 -> cause=10 until done; mul in BUSY plus lw-use in the same cycle
//     -> cause=11.
//   lw $8 in EX, flush with dependent add in ID -> stall=0, EX shadow invalid next cycle.
//   rstn low during BUSY -> md_busy=0, md_dest=0 immediately; no md_done afterwards.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Issue-side hazard tracker for the 5-stage core. It keeps a shadow of the
//   register writer currently in EX and of the pending destination of the
//   multi-cycle mul/div unit. ID is stalled when a source cannot be served by
//   the EX-stage bypass network: load-use, or a mul/div result not yet produced.
//   Writers that have reached MEM are always forwardable, so no MEM-stage
//   state is needed to decide a stall.
//
// Ports
//   clk, rstn        core clock (rising edge), asynchronous active-low reset
//   ID_*             decoded fields of the instruction currently in ID
//   flush            squash the ID instruction and the EX shadow entry
//   stall, bubble    hold PC/IF-ID and insert a NOP into ID/EX (same signal)
//   stall_cause      {mul/div hazard, load-use hazard}
//   md_busy, md_dest mul/div operation in flight and its destination
//   md_done          one-cycle pulse when the mul/div result is valid
//
// Mul/div FSM
//   state   | meaning
//   MD_IDLE | no operation in flight
//   MD_BUSY | operation in flight, counter counts down to 1
//   MD_DONE | result valid this cycle; a new op may issue here

module hazard_scoreboard #(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 3
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       ID_valid,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_useRs,
    input  logic       ID_useRt,
    input  logic       ID_RegWrite,
    input  logic [1:0] ID_RegSrc,
    input  logic [4:0] ID_WriteReg,
    input  logic       ID_isMD,
    input  logic       flush,
    output logic       stall,
    output logic       bubble,
    output logic [1:0] stall_cause,
    output logic       md_busy,
    output logic [4:0] md_dest,
    output logic       md_done
);

    localparam logic [1:0] REGSRC_MEM = 2'b01;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } mdState_t;

    mdState_t         mdState;
    logic [CNT_W-1:0] mdCnt;

    logic       exValid;
    logic       exIsLoad;
    logic [4:0] exWriteReg;

    logic loadUse;
    logic mdSrcHit;
    logic mdHaz;
    logic hazValid;
    logic issue;

    assign loadUse = exValid & exIsLoad & (exWriteReg != 5'd0) &
                     ((ID_useRs & (ID_rs == exWriteReg)) |
                      (ID_useRt & (ID_rt == exWriteReg)));

    // md_dest is forced to 0 when idle, so the nonzero test also keeps $0 hazard-free
    assign mdSrcHit = (md_dest != 5'd0) &
                      ((ID_useRs & (ID_rs == md_dest)) |
                       (ID_useRt & (ID_rt == md_dest)));

    // Single mul/div unit: any second mul/div waits, as does a WAW on its destination
    assign mdHaz = (mdState == MD_BUSY) &
                   (mdSrcHit | ID_isMD |
                    (ID_RegWrite & (ID_WriteReg != 5'd0) & (ID_WriteReg == md_dest)));

    assign hazValid    = ID_valid & ~flush;
    assign stall       = hazValid & (loadUse | mdHaz);
    assign bubble      = stall;
    assign stall_cause = hazValid ? {mdHaz, loadUse} : 2'b00;
    assign issue       = ID_valid & ~stall & ~flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            exValid    <= 1'b0;
            exIsLoad   <= 1'b0;
            exWriteReg <= 5'd0;
        end else begin
            exValid    <= issue & ID_RegWrite;
            exIsLoad   <= ID_RegSrc == REGSRC_MEM;
            exWriteReg <= ID_WriteReg;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mdState <= MD_IDLE;
            mdCnt   <= '0;
            md_busy <= 1'b0;
            md_dest <= 5'd0;
            md_done <= 1'b0;
        end else begin
            md_done <= 1'b0;
            unique case (mdState)
                MD_BUSY: begin
                    if (mdCnt == CNT_W'(1)) begin
                        mdState <= MD_DONE;
                        mdCnt   <= '0;
                        md_busy <= 1'b0;
                        md_dest <= 5'd0;
                        md_done <= 1'b1;
                    end else begin
                        mdCnt <= mdCnt - 1'b1;
                    end
                end
                default: begin
                    // DONE behaves like IDLE so a back-to-back op can issue
                    if (issue & ID_isMD) begin
                        mdState <= MD_BUSY;
                        mdCnt   <= CNT_W'(MD_LAT);
                        md_busy <= 1'b1;
                        md_dest <= ID_WriteReg;
                    end else begin
                        mdState <= MD_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
//   Drives short instruction sequences into hazard_scoreboard. For every cycle
//   the expected outputs are pushed to a queue as the stimulus is applied and
//   popped and compared at the falling edge.

module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rstn;
    logic       ID_valid;
    logic [4:0] ID_rs;
    logic [4:0] ID_rt;
    logic       ID_useRs;
    logic       ID_useRt;
    logic       ID_RegWrite;
    logic [1:0] ID_RegSrc;
    logic [4:0] ID_WriteReg;
    logic       ID_isMD;
    logic       flush;
    logic       stall;
    logic       bubble;
    logic [1:0] stall_cause;
    logic       md_busy;
    logic [4:0] md_dest;
    logic       md_done;

    typedef struct packed {
        logic       stall;
        logic [1:0] cause;
        logic       busy;
        logic [4:0] dest;
        logic       done;
    } expOut_t;

    expOut_t expQ[$];
    string   tagQ[$];
    int      checkCount = 0;
    int      passCount  = 0;

    hazard_scoreboard #(.MD_LAT(4), .CNT_W(3)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .ID_valid    (ID_valid),
        .ID_rs       (ID_rs),
        .ID_rt       (ID_rt),
        .ID_useRs    (ID_useRs),
        .ID_useRt    (ID_useRt),
        .ID_RegWrite (ID_RegWrite),
        .ID_RegSrc   (ID_RegSrc),
        .ID_WriteReg (ID_WriteReg),
        .ID_isMD     (ID_isMD),
        .flush       (flush),
        .stall       (stall),
        .bubble      (bubble),
        .stall_cause (stall_cause),
        .md_busy     (md_busy),
        .md_dest     (md_dest),
        .md_done     (md_done)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checkCount++;
        if (got !== exp)
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        else
            passCount++;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic uRs, input logic uRt, input logic rw,
                         input logic [1:0] src, input logic [4:0] wr,
                         input logic md, input logic fl);
        ID_valid    = v;
        ID_rs       = rs;
        ID_rt       = rt;
        ID_useRs    = uRs;
        ID_useRt    = uRt;
        ID_RegWrite = rw;
        ID_RegSrc   = src;
        ID_WriteReg = wr;
        ID_isMD     = md;
        flush       = fl;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic lw(input logic [4:0] rd, input logic [4:0] base);
        drive(1'b1, base, 5'd0, 1'b1, 1'b0, 1'b1, 2'b01, rd, 1'b0, 1'b0);
    endtask

    task automatic add(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b,
                       input logic fl);
        drive(1'b1, a, b, 1'b1, 1'b1, 1'b1, 2'b00, rd, 1'b0, fl);
    endtask

    task automatic mul(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
        drive(1'b1, a, b, 1'b1, 1'b1, 1'b1, 2'b00, rd, 1'b1, 1'b0);
    endtask

    // One cycle: register the expectation, compare at the falling edge,
    // then move to just after the next rising edge for the next stimulus.
    task automatic step(input string tag, input logic s, input logic [1:0] c,
                        input logic b, input logic [4:0] d, input logic dn);
        expOut_t e;
        string   t;
        expQ.push_back('{stall: s, cause: c, busy: b, dest: d, done: dn});
        tagQ.push_back(tag);
        @(negedge clk);
        e = expQ.pop_front();
        t = tagQ.pop_front();
        checkVal({t, ".stall"},  {7'd0, stall},       {7'd0, e.stall});
        checkVal({t, ".bubble"}, {7'd0, bubble},      {7'd0, e.stall});
        checkVal({t, ".cause"},  {6'd0, stall_cause}, {6'd0, e.cause});
        checkVal({t, ".busy"},   {7'd0, md_busy},     {7'd0, e.busy});
        checkVal({t, ".dest"},   {3'd0, md_dest},     {3'd0, e.dest});
        checkVal({t, ".done"},   {7'd0, md_done},     {7'd0, e.done});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0;
        idle();
        step("reset", 1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
        rstn = 1'b1;

        // lw $8 ; add $9,$8,$10 -> one load-use stall cycle
        lw(5'd8, 5'd1);            step("lu.lw",    1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
        add(5'd9, 5'd8, 5'd10, 0); step("lu.stall", 1'b1, 2'b01, 1'b0, 5'd0, 1'b0);
        add(5'd9, 5'd8, 5'd10, 0); step("lu.issue", 1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
        idle();                    step("lu.idle",  1'b0, 2'b00, 1'b0, 5'd0, 1'b0);

        // lw $8 ; nop ; add $9,$8,$8 -> no stall
        lw(5'd8, 5'd1);            step("gap.lw",   1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
        idle();                    step("gap.nop",  1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
        add(5'd9, 5'd8, 5'd8, 0);  step("gap.add",  1'b0, 2'b00, 1'b0, 5'd0, 1'b0);

        // lw $0 ; add $9,$0,$0 -> register 0 never hazards
        lw(5'd0, 5'd1);            step("r0.lw",    1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
        add(5'd9, 5'd0, 5'd0, 0);  step("r0.add",   1'b0, 2'b00, 1'b0, 5'd0, 1'b0);

        // mul $5 ; add $6,$5,$1 (with a WAW lw $5 mixed in) -> stall until md_done
        mul(5'd5, 5'd2, 5'd3);     step("md.mul",   1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
        add(5'd6, 5'd5, 5'd1, 0);  step("md.b1",    1'b1, 2'b10, 1'b1, 5'd5, 1'b0);
        lw(5'd5, 5'd1);            step("md.waw",   1'b1, 2'b10, 1'b1, 5'd5, 1'b0);
        add(5'd6, 5'd5, 5'd1, 0);  step("md.b3",    1'b1, 2'b10, 1'b1, 5'd5, 1'b0);
        add(5'd6, 5'd5, 5'd1, 0);  step("md.b4",    1'b1, 2'b10, 1'b1, 5'd5, 1'b0);
        add(5'd6, 5'd5, 5'd1, 0);  step("md.done",  1'b0, 2'b00, 1'b0, 5'd0, 1'b1);
        idle();                    step("md.idle",  1'b0, 2'b00, 1'b0, 5'd0, 1'b0);

        // mul $5 ; div $7 -> structural stall, div issues in the DONE cycle
        mul(5'd5, 5'd2, 5'd3);     step("dd.mul",   1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            mul(5'd7, 5'd2, 5'd3); step("dd.wait",  1'b1, 2'b10, 1'b1, 5'd5, 1'b0);
        end
        mul(5'd7, 5'd2, 5'd3);     step("dd.issue", 1'b0, 2'b00, 1'b0, 5'd0, 1'b1);
        // div $7 busy; lw $8 then add $9,$8,$7 -> both causes, then mul/div only
        lw(5'd8, 5'd1);            step("both.lw",  1'b0, 2'b00, 1'b1, 5'd7, 1'b0);
        add(5'd9, 5'd8, 5'd7, 0);  step("both.11",  1'b1, 2'b11, 1'b1, 5'd7, 1'b0);
        add(5'd9, 5'd8, 5'd7, 0);  step("both.10a", 1'b1, 2'b10, 1'b1, 5'd7, 1'b0);
        add(5'd9, 5'd8, 5'd7, 0);  step("both.10b", 1'b1, 2'b10, 1'b1, 5'd7, 1'b0);
        add(5'd9, 5'd8, 5'd7, 0);  step("both.done",1'b0, 2'b00, 1'b0, 5'd0, 1'b1);
        idle();                    step("both.idle",1'b0, 2'b00, 1'b0, 5'd0, 1'b0);

        // flush with a dependent add in ID -> no stall, EX shadow dropped
        lw(5'd8, 5'd1);            step("fl.lw",    1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
        add(5'd9, 5'd8, 5'd10, 1); step("fl.flush", 1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
        add(5'd9, 5'd8, 5'd10, 0); step("fl.after", 1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
        idle();                    step("fl.idle",  1'b0, 2'b00, 1'b0, 5'd0, 1'b0);

        // reset while BUSY aborts the op with no md_done afterwards
        mul(5'd3, 5'd2, 5'd4);     step("rs.mul",   1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
        idle();                    step("rs.busy",  1'b0, 2'b00, 1'b1, 5'd3, 1'b0);
        rstn = 1'b0;               step("rs.low",   1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step("rs.nodone", 1'b0, 2'b00, 1'b0, 5'd0, 1'b0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
